// File: rtl/ram_bus_sampler_pkg.sv
// Shared definitions for the RAM bus sampler and the downstream packet formatter.
// Contents: FSM state encoding, default bus widths, overflow counter width and
// the trace packet layout.
package ram_bus_sampler_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT = 23;
  localparam int unsigned DATA_WIDTH_DEFAULT = 16;
  localparam int unsigned OVF_WIDTH          = 16;

  // Framing FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // One trace packet at the default widths
  typedef struct packed {
    logic [ADDR_WIDTH_DEFAULT-1:0] addr;
    logic [DATA_WIDTH_DEFAULT-1:0] data;
    logic                          write;
  } trace_pkt_t;

endpackage

// File: rtl/ram_bus_voter.sv
// Three-deep sample history with per-bit 2-of-3 majority voting.
// Ports:
//   clk, reset   clock and async active-high reset
//   bus          raw (already synchronized) input lines
//   voted_c      combinational per-bit majority of the three history stages
module ram_bus_voter
  import ram_bus_sampler_pkg::*;
#(
  parameter int unsigned     W         = 2,
  parameter logic [W-1:0]    RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] bus,
  output logic [W-1:0] voted_c
);

  logic [W-1:0] h0;
  logic [W-1:0] h1;
  logic [W-1:0] h2;

  // History shift register; reset to the idle bus pattern so no edge follows release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h0 <= RESET_VAL;
      h1 <= RESET_VAL;
      h2 <= RESET_VAL;
    end else begin
      h0 <= bus;
      h1 <= h0;
      h2 <= h1;
    end
  end

  // Per-bit majority-detect array
  for (genvar i = 0; i < int'(W); i++) begin : g_maj
    assign voted_c[i] = (h0[i] & h1[i]) | (h0[i] & h2[i]) | (h1[i] & h2[i]);
  end

endmodule

// File: rtl/ram_bus_sampler.sv
// Turns the synchronized external RAM bus into per-transaction trace packets.
// Ports:
//   clk, reset                          clock and async active-high reset
//   bus_addr/bus_data/bus_cs_n/bus_we_n synchronized RAM pins
//   pkt_valid/pkt_ready                 one-entry output handshake
//   pkt_addr/pkt_data/pkt_write         captured transaction
//   overflow_count                      saturating count of dropped packets
module ram_bus_sampler
  import ram_bus_sampler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned SETTLE     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_data,
  input  logic                  bus_cs_n,
  input  logic                  bus_we_n,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [ADDR_WIDTH-1:0] pkt_addr,
  output logic [DATA_WIDTH-1:0] pkt_data,
  output logic                  pkt_write,
  output logic [OVF_WIDTH-1:0]  overflow_count
);

  localparam int unsigned BUS_W = ADDR_WIDTH + DATA_WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(SETTLE + 1);
  localparam logic [BUS_W-1:0] BUS_IDLE = {2'b11, {(BUS_W-2){1'b0}}};

  logic [BUS_W-1:0]      voted_c;
  logic                  v_cs_n;
  logic                  v_we_n;
  logic [ADDR_WIDTH-1:0] v_addr;
  logic [DATA_WIDTH-1:0] v_data;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] last_data;
  logic                  emit_c;

  ram_bus_voter #(
    .W         (BUS_W),
    .RESET_VAL (BUS_IDLE)
  ) u_voter (
    .clk     (clk),
    .reset   (reset),
    .bus     ({bus_cs_n, bus_we_n, bus_addr, bus_data}),
    .voted_c (voted_c)
  );

  assign {v_cs_n, v_we_n, v_addr, v_data} = voted_c;

  // A framed cycle ends when voted cs_n returns high while ACTIVE
  assign emit_c = (state == ST_ACTIVE) && v_cs_n;

  // Framing FSM; abort in SETTLE takes priority over address capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      last_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!v_cs_n) begin
            state <= ST_SETTLE;
            cnt   <= CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (v_cs_n) begin
            state <= ST_IDLE;
          end else if (cnt == CNT_W'(SETTLE)) begin
            // Capture cycle also seeds data so a minimum-length frame carries valid data
            addr_q    <= v_addr;
            write_q   <= ~v_we_n;
            last_data <= v_data;
            state     <= ST_ACTIVE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (v_cs_n) begin
            state <= ST_IDLE;
          end else begin
            last_data <= v_data;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One-entry output register with drop-on-backpressure and saturating drop count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_valid      <= 1'b0;
      pkt_addr       <= '0;
      pkt_data       <= '0;
      pkt_write      <= 1'b0;
      overflow_count <= '0;
    end else if (emit_c) begin
      if (!pkt_valid || pkt_ready) begin
        pkt_valid <= 1'b1;
        pkt_addr  <= addr_q;
        pkt_data  <= last_data;
        pkt_write <= write_q;
      end else if (overflow_count != '1) begin
        overflow_count <= overflow_count + OVF_WIDTH'(1);
      end
    end else if (pkt_valid && pkt_ready) begin
      pkt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_bus_sampler.sv
// Scoreboard bench for ram_bus_sampler: stimulus pushes expected packets,
// a negedge monitor pops and compares on every handshake transfer.
module tb_ram_bus_sampler;
  import ram_bus_sampler_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [22:0] bus_addr = '0;
  logic [15:0] bus_data = '0;
  logic        bus_cs_n = 1'b1;
  logic        bus_we_n = 1'b1;
  logic        pkt_valid;
  logic        pkt_ready = 1'b1;
  logic [22:0] pkt_addr;
  logic [15:0] pkt_data;
  logic        pkt_write;
  logic [15:0] overflow_count;

  int checks = 0;
  int failures = 0;

  trace_pkt_t exp_q[$];

  ram_bus_sampler dut (
    .clk            (clk),
    .reset          (reset),
    .bus_addr       (bus_addr),
    .bus_data       (bus_data),
    .bus_cs_n       (bus_cs_n),
    .bus_we_n       (bus_we_n),
    .pkt_valid      (pkt_valid),
    .pkt_ready      (pkt_ready),
    .pkt_addr       (pkt_addr),
    .pkt_data       (pkt_data),
    .pkt_write      (pkt_write),
    .overflow_count (overflow_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cs_n, input logic we_n, input logic [22:0] a, input logic [15:0] d);
    bus_cs_n = cs_n;
    bus_we_n = we_n;
    bus_addr = a;
    bus_data = d;
  endtask

  // Hold cs_n low for 'low' clocks, then raise it (caller ticks afterwards)
  task automatic txn(input logic we_n, input logic [22:0] a, input logic [15:0] d, input int low);
    drive(1'b0, we_n, a, d);
    tick(low);
    drive(1'b1, 1'b1, a, d);
  endtask

  task automatic push(input logic [22:0] a, input logic [15:0] d, input logic w);
    trace_pkt_t p;
    p.addr  = a;
    p.data  = d;
    p.write = w;
    exp_q.push_back(p);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(pkt_valid), 64'd0);
    check({tag, "_addr"}, 64'(pkt_addr), 64'd0);
    check({tag, "_data"}, 64'(pkt_data), 64'd0);
    check({tag, "_write"}, 64'(pkt_write), 64'd0);
    check({tag, "_ovf"}, 64'(overflow_count), 64'd0);
  endtask

  // Monitor: compares each transferred packet and checks stability while stalled
  logic       held = 1'b0;
  trace_pkt_t held_pkt;
  always @(negedge clk) begin
    trace_pkt_t cur;
    trace_pkt_t e;
    cur.addr  = pkt_addr;
    cur.data  = pkt_data;
    cur.write = pkt_write;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_valid", 64'(pkt_valid), 64'd1);
        check("stall_pkt", 64'(cur), 64'(held_pkt));
      end
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pkt actual=0x%0h expected=none", cur);
        end else begin
          e = exp_q.pop_front();
          check("pkt", 64'(cur), 64'(e));
        end
      end
      held     = pkt_valid && !pkt_ready;
      held_pkt = cur;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check_reset_outputs("rst_hold");
    reset = 1'b0;

    // 1: idle bus after reset release
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t1_valid", 64'(pkt_valid), 64'd0);
      check("t1_ovf", 64'(overflow_count), 64'd0);
    end

    // 2: single write, with emit latency
    push(23'h012345, 16'hBEEF, 1'b1);
    txn(1'b0, 23'h012345, 16'hBEEF, 8);
    tick(1);
    tick(1);
    check("t2_lat_pre", 64'(pkt_valid), 64'd0);
    tick(1);
    check("t2_lat_rise", 64'(pkt_valid), 64'd1);
    tick(1);
    check("t2_drop", 64'(pkt_valid), 64'd0);
    tick(4);
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // 3: glitch and aborted frames produce nothing
    txn(1'b1, 23'h000055, 16'h0000, 1);
    tick(8);
    check("t3_glitch", 64'(pkt_valid), 64'd0);
    txn(1'b1, 23'h000066, 16'h0000, 2);
    tick(8);
    check("t3_abort", 64'(pkt_valid), 64'd0);
    check("t3_ovf", 64'(overflow_count), 64'd0);

    // 4: backpressure drops the second read
    pkt_ready = 1'b0;
    push(23'h000010, 16'h1111, 1'b0);
    txn(1'b1, 23'h000010, 16'h1111, 6);
    tick(6);
    txn(1'b1, 23'h000020, 16'h2222, 6);
    tick(6);
    check("t4_valid", 64'(pkt_valid), 64'd1);
    check("t4_addr", 64'(pkt_addr), 64'h10);
    check("t4_data", 64'(pkt_data), 64'h1111);
    check("t4_ovf", 64'(overflow_count), 64'd1);
    pkt_ready = 1'b1;
    tick(1);
    check("t4_drop", 64'(pkt_valid), 64'd0);
    check("t4_drained", 64'(exp_q.size()), 64'd0);

    // 5: transfer and load on the same edge
    pkt_ready = 1'b0;
    push(23'h000010, 16'h1111, 1'b0);
    txn(1'b1, 23'h000010, 16'h1111, 6);
    tick(6);
    txn(1'b1, 23'h000030, 16'h3333, 6);
    tick(2);
    pkt_ready = 1'b1;
    push(23'h000030, 16'h3333, 1'b0);
    tick(1);
    check("t5_valid", 64'(pkt_valid), 64'd1);
    check("t5_addr", 64'(pkt_addr), 64'h30);
    check("t5_ovf", 64'(overflow_count), 64'd1);
    tick(3);
    check("t5_drop", 64'(pkt_valid), 64'd0);
    check("t5_drained", 64'(exp_q.size()), 64'd0);

    // 6a: one-cycle data glitch in the last low cycle is voted out
    push(23'h000777, 16'hA5A5, 1'b1);
    drive(1'b0, 1'b0, 23'h000777, 16'hA5A5);
    tick(5);
    drive(1'b0, 1'b0, 23'h000777, 16'h0000);
    tick(1);
    drive(1'b1, 1'b1, 23'h000777, 16'hA5A5);
    tick(6);
    check("t6_drained", 64'(exp_q.size()), 64'd0);

    // 6b: reset while ACTIVE
    drive(1'b0, 1'b1, 23'h000999, 16'h1234);
    tick(8);
    reset = 1'b1;
    #1;
    check_reset_outputs("t6_rst_now");
    drive(1'b1, 1'b1, 23'h000000, 16'h0000);
    tick(2);
    check_reset_outputs("t6_rst_hold");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t6_post_valid", 64'(pkt_valid), 64'd0);
    end
    check("t6_post_ovf", 64'(overflow_count), 64'd0);
    check("t6_post_q", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
